// File: rtl/counter_pkg.sv
// counter_pkg -- shared helpers for the free-running counter block.
//
// Contents:
//   cnt_width(n) : ceil(log2(n)), never less than 1. Sizes the count register.
//
// Not used by this package, but documented here with the block:
//   COUNTER_CHECK_EN : when defined, counter_blk compiles its elaboration
//                      checks and simulation assertions.
package counter_pkg;

  // Number of bits needed to hold the values 0 .. n-1. The result is never
  // less than 1, so a single-state counter still has a real register bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(n)) begin
        w = i + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/counter_blk.sv
// counter_blk -- free-running modulo / saturating counter.
//
// Parameters:
//   MAX_CNT : number of count states, 0 .. MAX_CNT-1 (must be >= 1)
//   LOOP    : 1 = wrap to 0 after the terminal count, 0 = hold at the terminal count
//   CNT_W   : derived width of o_cnt_val
//
// Ports:
//   i_clk      in  1      sole clock; all state changes on its rising edge
//   i_rst      in  1      synchronous reset, active low
//   o_cnt_done out 1      high while o_cnt_val == MAX_CNT-1 (registered)
//   o_cnt_val  out CNT_W  current count (registered)
//
// Optional build macro:
//   COUNTER_CHECK_EN : adds elaboration checks on the parameters and simulation
//                      assertions on the outputs. The synthesized logic is the
//                      same with or without it.
module counter_blk
  import counter_pkg::*;
#(
  parameter  int MAX_CNT = 6,
  parameter  int LOOP    = 1,
  localparam int CNT_W   = cnt_width(MAX_CNT)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_cnt_done,
  output logic [CNT_W-1:0] o_cnt_val
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(MAX_CNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // The terminal count is detected explicitly, so no value above TERM is ever
  // produced, even when MAX_CNT is not a power of two.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == TERM) begin
      cnt_d = (LOOP != 0) ? '0 : TERM;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // The done flag is computed from the next count value. It is then
    // registered on the same edge as the count, so the two outputs never skew.
    done_d = (cnt_d == TERM);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign o_cnt_val  = cnt_q;
  assign o_cnt_done = done_q;

`ifdef COUNTER_CHECK_EN
  if (MAX_CNT < 1) begin : g_bad_max_cnt
    $error("counter_blk: MAX_CNT must be >= 1");
  end
  if (LOOP != 0 && LOOP != 1) begin : g_bad_loop
    $error("counter_blk: LOOP must be 0 or 1");
  end

  // Directly after a reset edge, the outputs are 0/0. For MAX_CNT == 1 that
  // breaks the done/value relation. So the relation is only checked once the
  // previous edge was a counting edge.
  logic chk_live_q;
  logic chk_wrap_q;

  always_ff @(posedge i_clk) begin
    chk_live_q <= i_rst;
    chk_wrap_q <= i_rst && chk_live_q && (cnt_q == TERM);
    if (chk_live_q) begin
      assert (cnt_q <= TERM)
        else $error("counter_blk: count %0d beyond terminal", cnt_q);
      assert (done_q == (cnt_q == TERM))
        else $error("counter_blk: done %0b inconsistent with count %0d", done_q, cnt_q);
    end
    if (LOOP == 1 && chk_wrap_q) begin
      assert (cnt_q == '0)
        else $error("counter_blk: no wrap after terminal count, got %0d", cnt_q);
    end
  end
`else
  `endif

endmodule

// File: tb/tb_counter_blk.sv
// tb_counter_blk -- self-checking bench for counter_blk.
//
// Four instances share one clock, and each instance has its own reset:
//   dut 0: MAX_CNT=6, LOOP=1
//   dut 1: MAX_CNT=6, LOOP=0
//   dut 2: MAX_CNT=1, LOOP=1
//   dut 3: MAX_CNT=8, LOOP=1
//
// The reference model only tracks how many counting edges each instance has
// seen since its last reset edge. The expected outputs come from that number:
//   LOOP=1 : value = edges mod MAX_CNT
//   LOOP=0 : value = min(edges, MAX_CNT-1)
module tb_counter_blk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_n;
  logic       done0, done1, done2, done3;
  logic [2:0] val0;
  logic [2:0] val1;
  logic [0:0] val2;
  logic [2:0] val3;

  counter_blk #(.MAX_CNT(6), .LOOP(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst_n[0]), .o_cnt_done(done0), .o_cnt_val(val0));
  counter_blk #(.MAX_CNT(6), .LOOP(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst_n[1]), .o_cnt_done(done1), .o_cnt_val(val1));
  counter_blk #(.MAX_CNT(1), .LOOP(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst_n[2]), .o_cnt_done(done2), .o_cnt_val(val2));
  counter_blk #(.MAX_CNT(8), .LOOP(1)) u_dut3 (
    .i_clk(clk), .i_rst(rst_n[3]), .o_cnt_done(done3), .o_cnt_val(val3));

  int max_cnt [4] = '{6, 6, 1, 8};
  int loop_en [4] = '{1, 0, 1, 1};
  int since   [4] = '{0, 0, 0, 0};   // counting edges since last reset edge

  int vectors     = 0;
  int miscompares = 0;

  function automatic int exp_val(input int d);
    if (since[d] == 0)  return 0;
    if (loop_en[d] != 0) return since[d] % max_cnt[d];
    return (since[d] < max_cnt[d] - 1) ? since[d] : max_cnt[d] - 1;
  endfunction

  function automatic logic exp_done(input int d);
    if (since[d] == 0) return 1'b0;
    return (exp_val(d) == max_cnt[d] - 1);
  endfunction

  task automatic check_all();
    int   act_val  [4];
    logic act_done [4];
    act_val[0]  = int'(val0);
    act_val[1]  = int'(val1);
    act_val[2]  = int'(val2);
    act_val[3]  = int'(val3);
    act_done[0] = done0;
    act_done[1] = done1;
    act_done[2] = done2;
    act_done[3] = done3;
    for (int d = 0; d < 4; d++) begin
      vectors++;
      assert (act_val[d] === exp_val(d))
        else begin
          miscompares++;
          $error("FAIL val dut%0d t=%0t got %0d want %0d", d, $time, act_val[d], exp_val(d));
        end
      vectors++;
      assert (act_done[d] === exp_done(d))
        else begin
          miscompares++;
          $error("FAIL done dut%0d t=%0t got %0b want %0b", d, $time, act_done[d], exp_done(d));
        end
    end
  endtask

  // One rising edge: update the model from the reset levels that were just
  // sampled, then check all instances 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      since[d] = rst_n[d] ? since[d] + 1 : 0;
    end
    check_all();
  endtask

  initial begin
    // Long reset: all outputs must stay at 0/0.
    rst_n = 4'b0000;
    repeat (31) tick();

    // Free run: wrap sequences, the hold at 5, the constant-0 counter, and 7->0.
    rst_n = 4'b1111;
    repeat (30) tick();

    // Reset for one edge while instance 0 shows 3. The loop is bounded by the
    // model alone and needs at most 6 edges.
    for (int n = 0; n < 8 && exp_val(0) != 3; n++) tick();
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    repeat (8) tick();

    // Random reset pulses on every instance, including during the hold.
    repeat (300) begin
      for (int d = 0; d < 4; d++) begin
        rst_n[d] = ($urandom_range(0, 9) != 0);
      end
      tick();
    end

    rst_n = 4'b1111;
    repeat (15) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_blk.md
COUNTER_BLK -- requirements
Module: counter

Interface
REQ-001 Parameter MAX_CNT, default 6, integer >= 1; number of count states (0 .. MAX_CNT-1).
REQ-002 Parameter LOOP, default 1; 1 = wrap to 0 after terminal count, 0 = stop and hold at terminal count.
REQ-003 Localparam CNT_W = max(1, ceil(log2(MAX_CNT))); width of the count output.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset; synchronous, active-low (0 = reset), sampled on the rising edge of i_clk.
REQ-006 o_cnt_done  output  1  terminal-count flag; high while the count equals MAX_CNT-1.
REQ-007 o_cnt_val  output  CNT_W  current count value, driven directly from a register.

Function
REQ-008 The counter SHALL be free-running: increment by 1 on every rising edge of i_clk when i_rst = 1; no enable input.
REQ-009 o_cnt_val and o_cnt_done SHALL both be registered outputs that update on the same edge, with no combinational path from any input.
REQ-010 o_cnt_done SHALL be 1 exactly in the cycles where o_cnt_val = MAX_CNT-1, and 0 otherwise.
REQ-011 LOOP = 1: on the edge after o_cnt_val = MAX_CNT-1, o_cnt_val SHALL become 0 and o_cnt_done 0, giving a one-cycle done pulse every MAX_CNT cycles.
REQ-012 LOOP = 0: on reaching MAX_CNT-1 the counter SHALL hold that value, with o_cnt_done held at 1, until reset.
REQ-013 MAX_CNT = 1: o_cnt_val SHALL stay at 0, and o_cnt_done SHALL be 1 in every non-reset cycle after the first post-reset edge, for either LOOP value.
REQ-014 o_cnt_val SHALL never exceed MAX_CNT-1, including when MAX_CNT is not a power of two; the arithmetic SHALL NOT rely on CNT_W overflow.

Reset
REQ-015 While i_rst = 0 at a rising edge, the next state SHALL be o_cnt_val = 0 and o_cnt_done = 0, regardless of the current state.
REQ-016 Reset SHALL take priority over counting, wrap and hold.
REQ-017 A reset asserted mid-count, or while holding with LOOP = 0, SHALL restart the sequence from 0.
REQ-018 After the edge at which i_rst is first sampled 1, o_cnt_val SHALL be 1 (or 0 with o_cnt_done = 1 when MAX_CNT = 1).
REQ-019 Outputs are undefined before the first reset edge; benches SHALL apply reset before checking.

Configuration
REQ-020 Macro COUNTER_CHECK_EN: when defined, the module SHALL include elaboration checks and simulation assertions; when undefined, it SHALL compile none of them, with identical synthesized logic either way.
REQ-021 The elaboration checks SHALL reject MAX_CNT < 1 and any LOOP value other than 0 or 1.
REQ-022 The simulation assertions SHALL enforce: o_cnt_val < MAX_CNT; o_cnt_done equal to (o_cnt_val == MAX_CNT-1); and, with LOOP = 1, wrap to 0 immediately after terminal count.

Structure
REQ-023 A shared package counter_pkg SHALL hold the width helper function (ceil-log2 clamped to a minimum of 1) used to derive CNT_W.
REQ-024 No sub-module SHALL be used: a single next-state block plus the register stage.

Verification
REQ-025 MAX_CNT=6, LOOP=1, i_rst held 0 for 31 clock edges -> o_cnt_val=0, o_cnt_done=0 throughout.
REQ-026 MAX_CNT=6, LOOP=1, release reset -> o_cnt_val sequence 1,2,3,4,5,0,1...; o_cnt_done=1 only while value=5, one cycle in every 6.
REQ-027 MAX_CNT=6, LOOP=0, release reset -> value reaches 5 after 5 edges and holds at 5 with o_cnt_done=1 for 20 further edges.
REQ-028 MAX_CNT=6, LOOP=1, assert i_rst=0 for one edge while value=3 -> next value 0, done 0, then 1,2,...
REQ-029 MAX_CNT=1 and MAX_CNT=8 (power of two), LOOP=1 -> MAX_CNT=1: value always 0, done 1 after reset release; MAX_CNT=8: value wraps 7->0 with CNT_W=3.
REQ-030 With COUNTER_CHECK_EN defined, run REQ-026..REQ-029 -> zero assertion failures; MAX_CNT=0 -> elaboration error.
